// File: rtl/mem_ctrl_pkg.sv
// Shared memory-controller definitions: arbiter FSM states, access-size and direction
// encodings, the latched command record and a word-base helper.
package mem_ctrl_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arbState_t;

  localparam logic [1:0] MAS_BYTE = 2'b00;
  localparam logic [1:0] MAS_HALF = 2'b01;
  localparam logic [1:0] MAS_WORD = 2'b10;
  localparam logic [1:0] MAS_BAD  = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef struct packed {
    logic              rw;
    logic [1:0]        mas;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } memCmd_t;

  function automatic logic [ADDR_W-1:0] wordBase(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_align_chk.sv
// Combinational alignment checker: flags the illegal size code and half/word accesses
// whose low address bits are not aligned to the access size.
module mem_align_chk
  import mem_ctrl_pkg::*;
(
  input  logic [1:0] i_mas,
  input  logic [1:0] i_a,
  output logic       o_fault
);

  always_comb begin
    o_fault = 1'b0;
    case (i_mas)
      MAS_BYTE: o_fault = 1'b0;
      MAS_HALF: o_fault = i_a[0];
      MAS_WORD: o_fault = (i_a != 2'b00);
      MAS_BAD:  o_fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: round-robin between a fetch and a data requester onto one RAM
// port, with alignment faulting and a bounded wait for the RAM to complete.
module mem_port_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [8:0]  i_addr,
  output logic        i_ack,
  output logic        i_err,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [1:0]  d_mas,
  input  logic [8:0]  d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_enable,
  output logic        mem_rw,
  output logic [8:0]  mem_address,
  output logic [1:0]  mem_A,
  output logic [1:0]  mem_MAS,
  output logic [31:0] mem_dataIn,
  input  logic [31:0] mem_dataOut,
  input  logic        mem_done
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arbState_t        r_state;
  arbState_t        w_nextState;
  memCmd_t          r_cmd;
  memCmd_t          w_selCmd;
  logic             r_grantData;
  logic             r_lastData;
  logic             r_respErr;
  logic [CNT_W-1:0] r_waitCnt;
  logic [31:0]      r_iRdata;
  logic [31:0]      r_dRdata;
  logic             w_anyReq;
  logic             w_grantData;
  logic             w_grant;
  logic             w_fault;
  logic             w_timeout;

  // r_lastData resets low so that the very first tie goes to the data port.
  always_comb begin
    w_grantData = d_req;
    if (d_req && i_req) begin
      w_grantData = ~r_lastData;
    end
  end

  assign w_anyReq  = i_req | d_req;
  assign w_grant   = (r_state == IDLE) && w_anyReq;
  assign w_timeout = !mem_done && (r_waitCnt == CNT_LAST);

  always_comb begin
    w_selCmd = '0;
    if (w_grantData) begin
      w_selCmd.rw    = d_rw;
      w_selCmd.mas   = d_mas;
      w_selCmd.addr  = d_addr;
      w_selCmd.wdata = d_wdata;
    end else begin
      w_selCmd.rw    = RW_READ;
      w_selCmd.mas   = MAS_WORD;
      w_selCmd.addr  = i_addr;
      w_selCmd.wdata = '0;
    end
  end

  mem_align_chk u_alignChk (
    .i_mas   (w_selCmd.mas),
    .i_a     (w_selCmd.addr[1:0]),
    .o_fault (w_fault)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_nextState = w_fault ? RESP : ISSUE;
        end
      end
      ISSUE: w_nextState = WAIT;
      WAIT: begin
        if (mem_done || w_timeout) begin
          w_nextState = RESP;
        end
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    mem_enable = 1'b0;
    i_ack      = 1'b0;
    i_err      = 1'b0;
    d_ack      = 1'b0;
    d_err      = 1'b0;
    case (r_state)
      ISSUE, WAIT: mem_enable = 1'b1;
      RESP: begin
        i_ack = !r_grantData && !r_respErr;
        i_err = !r_grantData &&  r_respErr;
        d_ack =  r_grantData && !r_respErr;
        d_err =  r_grantData &&  r_respErr;
      end
      default: ;
    endcase
  end

  // Command registers are only loaded on a grant, so requester changes mid-access are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd       <= '0;
      r_grantData <= 1'b0;
      r_lastData  <= 1'b0;
      r_respErr   <= 1'b0;
      r_waitCnt   <= '0;
      r_iRdata    <= '0;
      r_dRdata    <= '0;
    end else begin
      if (w_grant) begin
        r_cmd       <= w_selCmd;
        r_grantData <= w_grantData;
        r_lastData  <= w_grantData;
        r_respErr   <= w_fault;
      end
      if (r_state == WAIT) begin
        if (mem_done) begin
          r_respErr <= 1'b0;
          if (r_cmd.rw == RW_READ) begin
            if (r_grantData) begin
              r_dRdata <= mem_dataOut;
            end else begin
              r_iRdata <= mem_dataOut;
            end
          end
        end else if (w_timeout) begin
          r_respErr <= 1'b1;
        end
        r_waitCnt <= mem_done ? '0 : r_waitCnt + 1'b1;
      end else begin
        r_waitCnt <= '0;
      end
    end
  end

  assign mem_rw      = mem_enable & r_cmd.rw;
  assign mem_address = mem_enable ? wordBase(r_cmd.addr) : '0;
  assign mem_A       = mem_enable ? r_cmd.addr[1:0] : '0;
  assign mem_MAS     = mem_enable ? r_cmd.mas : '0;
  assign mem_dataIn  = (mem_enable && r_cmd.rw == RW_WRITE) ? r_cmd.wdata : '0;
  assign i_rdata     = r_iRdata;
  assign d_rdata     = r_dRdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses push expected responses,
// a monitor pops and compares them whenever an ack or err appears.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [8:0]  i_addr;
  logic        i_ack;
  logic        i_err;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_rw;
  logic [1:0]  d_mas;
  logic [8:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] d_rdata;
  logic        mem_enable;
  logic        mem_rw;
  logic [8:0]  mem_address;
  logic [1:0]  mem_A;
  logic [1:0]  mem_MAS;
  logic [31:0] mem_dataIn;
  logic [31:0] mem_dataOut;
  logic        mem_done;

  mem_port_arbiter #(.TIMEOUT_CYCLES(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_ack       (i_ack),
    .i_err       (i_err),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_rw        (d_rw),
    .d_mas       (d_mas),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ack       (d_ack),
    .d_err       (d_err),
    .d_rdata     (d_rdata),
    .mem_enable  (mem_enable),
    .mem_rw      (mem_rw),
    .mem_address (mem_address),
    .mem_A       (mem_A),
    .mem_MAS     (mem_MAS),
    .mem_dataIn  (mem_dataIn),
    .mem_dataOut (mem_dataOut),
    .mem_done    (mem_done)
  );

  typedef struct {
    bit          port;
    bit          isErr;
    logic [31:0] rdata;
    int          cycle;
    int          enCycles;
    bit          chkCmd;
    logic [8:0]  addr;
    logic [1:0]  a;
    logic [1:0]  mas;
    bit          rw;
    logic [31:0] dataIn;
  } expT;

  expT         expQ[$];
  int          checkCount = 0;
  int          passCount  = 0;
  int          cycleCount = 0;
  int          enTotal    = 0;
  int          curCnt     = 0;
  int          monEnMark  = 0;
  int          ramDelay   = 0;
  bit          ramEarly   = 1'b0;
  logic [31:0] ramData    = '0;
  logic [8:0]  accAddr    = '0;
  logic [1:0]  accA       = '0;
  logic [1:0]  accMas     = '0;
  logic        accRw      = 1'b0;
  logic [31:0] accDataIn  = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      passCount++;
    end
  endtask

  task automatic pushExp(input bit port, input bit isErr, input logic [31:0] rdata,
                         input int cycle, input int enCycles, input bit chkCmd,
                         input logic [8:0] addr, input logic [1:0] a, input logic [1:0] mas,
                         input bit rw, input logic [31:0] dataIn);
    expT e;
    e.port = port;   e.isErr = isErr;       e.rdata = rdata;
    e.cycle = cycle; e.enCycles = enCycles; e.chkCmd = chkCmd;
    e.addr = addr;   e.a = a;               e.mas = mas;
    e.rw = rw;       e.dataIn = dataIn;
    expQ.push_back(e);
  endtask

  // Called at a falling edge while the DUT is idle; that cycle becomes cycle 0.
  task automatic applyStimulus(input bit useI, input logic [8:0] iA, input bit useD,
                               input bit rw, input logic [1:0] mas, input logic [8:0] dA,
                               input logic [31:0] wd, input int delay, input bit early,
                               input logic [31:0] rd, output int start);
    ramDelay = delay;
    ramEarly = early;
    ramData  = rd;
    i_addr   = iA;
    d_rw     = rw;
    d_mas    = mas;
    d_addr   = dA;
    d_wdata  = wd;
    i_req    = useI;
    d_req    = useD;
    start    = cycleCount;
  endtask

  task automatic runUntilIdle(input int budget);
    int n = 0;
    while ((i_req || d_req) && n < budget) begin
      @(negedge clk);
      n++;
      if (i_ack || i_err) i_req = 1'b0;
      if (d_ack || d_err) d_req = 1'b0;
    end
    if (i_req || d_req) begin
      checkCount++;
      $display("[TB] FAIL response_wait: no response within %0d cycles, expected one", budget);
      i_req = 1'b0;
      d_req = 1'b0;
    end
    @(negedge clk);
  endtask

  // RAM model: completes in the Nth WAIT cycle (N = ramDelay, 0 = never).
  initial begin
    mem_done    = 1'b0;
    mem_dataOut = '0;
    forever begin
      @(negedge clk);
      if (mem_enable) begin
        curCnt++;
        enTotal++;
        accAddr   = mem_address;
        accA      = mem_A;
        accMas    = mem_MAS;
        accRw     = mem_rw;
        accDataIn = mem_dataIn;
      end else begin
        curCnt = 0;
      end
      mem_done = mem_enable && (ramDelay != 0) &&
                 ((curCnt == ramDelay + 1) || (ramEarly && curCnt < ramDelay + 1));
      mem_dataOut = mem_enable ? ramData : 32'h0;
    end
  end

  initial begin
    expT         e;
    int          enNow;
    bit          port;
    bit          isErr;
    logic [31:0] rd;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        monEnMark = enTotal;
        continue;
      end
      if (i_ack || i_err || d_ack || d_err) begin
        enNow     = enTotal - monEnMark;
        monEnMark = enTotal;
        if ((i_ack || i_err) && (d_ack || d_err)) begin
          checkCount++;
          $display("[TB] FAIL dual_response: both ports responded at cycle %0d, expected one", cycleCount);
        end
        port  = d_ack || d_err;
        isErr = port ? d_err : i_err;
        rd    = port ? d_rdata : i_rdata;
        if (expQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpected_response: port %0d at cycle %0d, expected none", port, cycleCount);
        end else begin
          e = expQ.pop_front();
          checkOutput("resp_port", 32'(port), 32'(e.port));
          checkOutput("resp_is_err", 32'(isErr), 32'(e.isErr));
          checkOutput("resp_cycle", cycleCount, e.cycle);
          checkOutput("resp_rdata", rd, e.rdata);
          checkOutput("enable_cycles", enNow, e.enCycles);
          if (e.chkCmd) begin
            checkOutput("mem_address", 32'(accAddr), 32'(e.addr));
            checkOutput("mem_A", 32'(accA), 32'(e.a));
            checkOutput("mem_MAS", 32'(accMas), 32'(e.mas));
            checkOutput("mem_rw", 32'(accRw), 32'(e.rw));
            if (!e.rw) checkOutput("mem_dataIn", accDataIn, e.dataIn);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    rst_n   = 1'b0;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_rw    = 1'b0;
    d_mas   = '0;
    d_addr  = '0;
    d_wdata = '0;
    #12;
    checkOutput("reset_i_ack", 32'(i_ack), 0);
    checkOutput("reset_i_err", 32'(i_err), 0);
    checkOutput("reset_i_rdata", i_rdata, 0);
    checkOutput("reset_d_ack", 32'(d_ack), 0);
    checkOutput("reset_d_err", 32'(d_err), 0);
    checkOutput("reset_d_rdata", d_rdata, 0);
    checkOutput("reset_mem_enable", 32'(mem_enable), 0);
    checkOutput("reset_mem_rw", 32'(mem_rw), 0);
    checkOutput("reset_mem_address", 32'(mem_address), 0);
    checkOutput("reset_mem_A", 32'(mem_A), 0);
    checkOutput("reset_mem_MAS", 32'(mem_MAS), 0);
    checkOutput("reset_mem_dataIn", mem_dataIn, 0);
    #10 rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] tie from reset: data write first, fetch second");
    applyStimulus(1, 9'h100, 1, 0, 2'b10, 9'h040, 32'h12345678, 2, 0, 32'hCAFEF00D, s);
    pushExp(1, 0, 32'h0, s + 4, 3, 1, 9'h040, 2'b00, 2'b10, 0, 32'h12345678);
    pushExp(0, 0, 32'hCAFEF00D, s + 9, 3, 1, 9'h100, 2'b00, 2'b10, 1, 32'h0);
    runUntilIdle(40);

    $display("[TB] repeated tie: data wins again after fetch");
    applyStimulus(1, 9'h104, 1, 1, 2'b10, 9'h044, 32'h0, 1, 0, 32'h0BADF00D, s);
    pushExp(1, 0, 32'h0BADF00D, s + 3, 2, 1, 9'h044, 2'b00, 2'b10, 1, 32'h0);
    pushExp(0, 0, 32'h0BADF00D, s + 7, 2, 1, 9'h104, 2'b00, 2'b10, 1, 32'h0);
    runUntilIdle(40);

    $display("[TB] word write, RAM done in third WAIT cycle");
    applyStimulus(0, 9'h0, 1, 0, 2'b10, 9'h010, 32'hDEADBEEF, 3, 0, 32'h0, s);
    pushExp(1, 0, 32'h0BADF00D, s + 5, 4, 1, 9'h010, 2'b00, 2'b10, 0, 32'hDEADBEEF);
    runUntilIdle(40);

    $display("[TB] byte read at 0x013");
    applyStimulus(0, 9'h0, 1, 1, 2'b00, 9'h013, 32'h0, 1, 0, 32'h000000EF, s);
    pushExp(1, 0, 32'h000000EF, s + 3, 2, 1, 9'h010, 2'b11, 2'b00, 1, 32'h0);
    runUntilIdle(40);

    $display("[TB] alignment faults");
    applyStimulus(0, 9'h0, 1, 1, 2'b01, 9'h021, 32'h0, 1, 0, 32'h11111111, s);
    pushExp(1, 1, 32'h000000EF, s + 1, 0, 0, 9'h0, 2'b00, 2'b00, 0, 32'h0);
    runUntilIdle(10);
    applyStimulus(0, 9'h0, 1, 1, 2'b11, 9'h021, 32'h0, 1, 0, 32'h11111111, s);
    pushExp(1, 1, 32'h000000EF, s + 1, 0, 0, 9'h0, 2'b00, 2'b00, 0, 32'h0);
    runUntilIdle(10);
    applyStimulus(0, 9'h0, 1, 0, 2'b10, 9'h022, 32'h22222222, 1, 0, 32'h11111111, s);
    pushExp(1, 1, 32'h000000EF, s + 1, 0, 0, 9'h0, 2'b00, 2'b00, 0, 32'h0);
    runUntilIdle(10);
    applyStimulus(1, 9'h0F9, 0, 0, 2'b00, 9'h0, 32'h0, 1, 0, 32'h11111111, s);
    pushExp(0, 1, 32'h0BADF00D, s + 1, 0, 0, 9'h0, 2'b00, 2'b00, 0, 32'h0);
    runUntilIdle(10);

    $display("[TB] aligned half read at 0x022");
    applyStimulus(0, 9'h0, 1, 1, 2'b01, 9'h022, 32'h0, 1, 0, 32'h0000BEEF, s);
    pushExp(1, 0, 32'h0000BEEF, s + 3, 2, 1, 9'h020, 2'b10, 2'b01, 1, 32'h0);
    runUntilIdle(40);

    $display("[TB] mem_done already high during ISSUE");
    applyStimulus(0, 9'h0, 1, 1, 2'b10, 9'h0C0, 32'h0, 1, 1, 32'h5A5AA5A5, s);
    pushExp(1, 0, 32'h5A5AA5A5, s + 3, 2, 1, 9'h0C0, 2'b00, 2'b10, 1, 32'h0);
    runUntilIdle(40);

    $display("[TB] RAM never completes: timeout");
    applyStimulus(0, 9'h0, 1, 1, 2'b10, 9'h080, 32'h0, 0, 0, 32'h99999999, s);
    pushExp(1, 1, 32'h5A5AA5A5, s + 66, 65, 1, 9'h080, 2'b00, 2'b10, 1, 32'h0);
    runUntilIdle(100);
    applyStimulus(1, 9'h0F8, 0, 0, 2'b00, 9'h0, 32'h0, 2, 0, 32'h76543210, s);
    pushExp(0, 0, 32'h76543210, s + 4, 3, 1, 9'h0F8, 2'b00, 2'b10, 1, 32'h0);
    runUntilIdle(40);

    $display("[TB] reset asserted during WAIT");
    applyStimulus(0, 9'h0, 1, 1, 2'b10, 9'h0A0, 32'h0, 0, 0, 32'h0, s);
    repeat (6) @(negedge clk);
    checkOutput("pre_reset_mem_enable", 32'(mem_enable), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_mem_enable", 32'(mem_enable), 0);
    checkOutput("async_reset_d_ack", 32'(d_ack), 0);
    checkOutput("async_reset_d_err", 32'(d_err), 0);
    checkOutput("async_reset_d_rdata", d_rdata, 0);
    checkOutput("async_reset_i_rdata", i_rdata, 0);
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] tie after reset: data half write first");
    applyStimulus(1, 9'h008, 1, 0, 2'b01, 9'h032, 32'h0000ABCD, 2, 0, 32'h13579BDF, s);
    pushExp(1, 0, 32'h0, s + 4, 3, 1, 9'h030, 2'b10, 2'b01, 0, 32'h0000ABCD);
    pushExp(0, 0, 32'h13579BDF, s + 9, 3, 1, 9'h008, 2'b00, 2'b10, 1, 32'h0);
    runUntilIdle(40);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
